// File: rtl/ref_pkg.sv
// ref_pkg: shared state encoding and parameter defaults for the refresh scheduler.
package ref_pkg;

    typedef enum logic [1:0] {IDLE, PEND, URG, GAP} state_e;

    localparam int DIV_DEF        = 250;
    localparam int URG_THRESH_DEF = 2;
    localparam int MAX_DEBT_DEF   = 7;
    localparam int IDLE_CYC_DEF   = 4;

endpackage

// File: rtl/ref_timer.sv
// ref_timer: refresh interval counter, one-cycle Tick every DIV clocks.
module ref_timer
    import ref_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic CLK,
    input  logic nRESET,
    output logic Tick
);

    localparam logic [7:0] LOAD = 8'(DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    assign Tick  = cnt_q == 8'd0;
    assign cnt_d = Tick ? LOAD : cnt_q - 8'd1;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) cnt_q <= LOAD;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ref_sched.sv
// ref_sched: DRAM refresh scheduler tracking owed refreshes and raising RefReq/RefUrg.
// Optional `REF_IDLE_EN promotes a pending refresh to urgent after IDLE_CYC idle bus cycles.
module ref_sched
    import ref_pkg::*;
#(
    parameter int DIV        = DIV_DEF,
    parameter int URG_THRESH = URG_THRESH_DEF,
    parameter int MAX_DEBT   = MAX_DEBT_DEF,
    parameter int IDLE_CYC   = IDLE_CYC_DEF
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       BACT,
    input  logic       RefAck,
    output logic       RefReq,
    output logic       RefUrg,
    output logic [3:0] Debt,
    output logic       RefOvf
);

    localparam logic [3:0] MAX = 4'(MAX_DEBT);
    localparam logic [3:0] THR = 4'(URG_THRESH);

    logic       tick, ack, ack_ok, idle_hit;
    logic       ack_q, ovf_q, ovf_d;
    logic [3:0] debt_q, debt_d;
    state_e     state_q, state_d;

    ref_timer #(.DIV(DIV)) u_timer (.CLK(CLK), .nRESET(nRESET), .Tick(tick));

    assign ack    = RefAck & ~ack_q;
    assign ack_ok = ack && debt_q != 4'd0;

`ifdef REF_IDLE_EN
    logic [3:0] idle_q, idle_d;

    assign idle_d   = BACT ? 4'd0 : (idle_q == 4'd15 ? idle_q : idle_q + 4'd1);
    assign idle_hit = idle_d >= 4'(IDLE_CYC);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) idle_q <= 4'd0;
        else         idle_q <= idle_d;
    end
`else
    logic unused_bact;

    assign unused_bact = BACT;
    assign idle_hit    = 1'b0;
`endif

    // a coincident tick and ack cancel out, so the saturation check only sees lone ticks
    always_comb begin
        debt_d = debt_q;
        ovf_d  = ovf_q;
        if (tick && !ack_ok) begin
            if (debt_q == MAX) ovf_d = 1'b1;
            else               debt_d = debt_q + 4'd1;
        end else if (!tick && ack_ok) begin
            debt_d = debt_q - 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = debt_d != 4'd0 ? PEND : IDLE;
            PEND: state_d = ack ? GAP : (debt_d >= THR || idle_hit) ? URG : PEND;
            URG:  state_d = ack ? GAP : URG;
            GAP:  state_d = debt_d == 4'd0 ? IDLE : debt_d >= THR ? URG : PEND;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= IDLE;
            debt_q  <= 4'd0;
            ovf_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            debt_q  <= debt_d;
            ovf_q   <= ovf_d;
            ack_q   <= RefAck;
        end
    end

    assign RefReq = state_q == PEND || state_q == URG;
    assign RefUrg = state_q == URG;
    assign Debt   = debt_q;
    assign RefOvf = ovf_q;

endmodule

// File: tb/tb_ref_sched.sv
// tb_ref_sched: directed test of ref_sched with DIV=10, URG_THRESH=2, MAX_DEBT=7, IDLE_CYC=4.
module tb_ref_sched;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic       BACT = 1'b1;
    logic       RefAck = 1'b0;
    logic       RefReq, RefUrg, RefOvf;
    logic [3:0] Debt;
    int         total = 0;
    int         bad = 0;

    ref_sched #(.DIV(10), .URG_THRESH(2), .MAX_DEBT(7), .IDLE_CYC(4)) dut (
        .CLK(CLK), .nRESET(nRESET), .BACT(BACT), .RefAck(RefAck),
        .RefReq(RefReq), .RefUrg(RefUrg), .Debt(Debt), .RefOvf(RefOvf)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] d, input logic rq, input logic ur);
        chk({tag, ".debt"}, 8'(Debt), 8'(d));
        chk({tag, ".req"}, 8'(RefReq), 8'(rq));
        chk({tag, ".urg"}, 8'(RefUrg), 8'(ur));
    endtask

    initial begin
        @(negedge CLK);
        cyc(2);
        chk_out("rst", 4'd0, 1'b0, 1'b0);
        chk("rst.ovf", 8'(RefOvf), 8'd0);
        nRESET = 1'b1;
        // first tick lands on the 10th edge after release
        cyc(9);
        chk_out("pre_tick", 4'd0, 1'b0, 1'b0);
        cyc(1);
        chk_out("tick1", 4'd1, 1'b1, 1'b0);
        cyc(10);
        chk_out("tick2", 4'd2, 1'b1, 1'b1);
        // ack coincident with tick at Debt=2
        cyc(9);
        RefAck = 1'b1;
        cyc(1);
        chk_out("coinc_gap", 4'd2, 1'b0, 1'b0);
        RefAck = 1'b0;
        cyc(1);
        chk_out("coinc_urg", 4'd2, 1'b1, 1'b1);
        RefAck = 1'b1;
        cyc(1);
        chk_out("ack_2to1", 4'd1, 1'b0, 1'b0);
        RefAck = 1'b0;
        cyc(1);
        chk_out("pend1", 4'd1, 1'b1, 1'b0);
        // 3-cycle held ack counts once
        RefAck = 1'b1;
        cyc(1);
        chk_out("held_gap", 4'd0, 1'b0, 1'b0);
        cyc(1);
        chk_out("held_idle", 4'd0, 1'b0, 1'b0);
        cyc(1);
        chk_out("held_end", 4'd0, 1'b0, 1'b0);
        RefAck = 1'b0;
        cyc(1);
        RefAck = 1'b1;
        cyc(1);
        chk_out("ack_at0", 4'd0, 1'b0, 1'b0);
        chk("ack_at0.ovf", 8'(RefOvf), 8'd0);
        RefAck = 1'b0;
        cyc(2);
        chk_out("tick4", 4'd1, 1'b1, 1'b0);
        // saturate: ticks at 50..100 bring Debt to 7, tick at 110 overflows
        cyc(60);
        chk_out("debt7", 4'd7, 1'b1, 1'b1);
        chk("debt7.ovf", 8'(RefOvf), 8'd0);
        cyc(10);
        chk_out("sat", 4'd7, 1'b1, 1'b1);
        chk("sat.ovf", 8'(RefOvf), 8'd1);
        RefAck = 1'b1;
        cyc(1);
        chk_out("sat_ack", 4'd6, 1'b0, 1'b0);
        chk("sat_ack.ovf", 8'(RefOvf), 8'd1);
        RefAck = 1'b0;
        cyc(1);
        chk_out("sat_urg", 4'd6, 1'b1, 1'b1);
        RefAck = 1'b1;
        cyc(1);
        RefAck = 1'b0;
        cyc(1);
        chk_out("debt5", 4'd5, 1'b1, 1'b1);
        // asynchronous reset mid-operation
        nRESET = 1'b0;
        #1;
        chk_out("arst", 4'd0, 1'b0, 1'b0);
        chk("arst.ovf", 8'(RefOvf), 8'd0);
        cyc(2);
        nRESET = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            chk("post_rst.req", 8'(RefReq), 8'd0);
        end
        cyc(1);
        chk_out("post_rst.tick", 4'd1, 1'b1, 1'b0);
`ifdef REF_IDLE_EN
        for (int i = 0; i < 9; i++) begin
            BACT = ((i / 3) % 2) == 1;
            cyc(1);
            chk("toggle.urg", 8'(RefUrg), 8'd0);
        end
        BACT = 1'b1;
        nRESET = 1'b0;
        cyc(2);
        nRESET = 1'b1;
        cyc(10);
        BACT = 1'b0;
        cyc(3);
        chk("idle3.urg", 8'(RefUrg), 8'd0);
        cyc(1);
        chk_out("idle4", 4'd1, 1'b1, 1'b1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
